fifo_mimo: RTL and testbench
============================

// Module: fifo_mimo
// PURPOSE
//  Generalised multi-write/multi-read FIFO: W_CNT writes and R_CNT reads per cycle, in order,
//  on one shared circular buffer with exact occupancy tracking. Used between fetch/decode/
//  issue stages where per-cycle producer and consumer widths differ (e.g. 4-wide in, 2-wide out).
//  Adds partial-accept by free space, occupancy/free-count outputs and a sync flush.
// PARAMETERS
//  WIDTH        32  data bits per entry
//  DEPTH        16  total entries; power of 2; DEPTH >= max(W_CNT, R_CNT)
//  W_CNT         4  write ports per cycle (>=1)
//  R_CNT         2  read ports per cycle (>=1)
//  ALWAYS_READ   1  1: head entries always presented, o_r_valid = occupancy; 0: o_r_valid = o_r_ack
// PORTS
//  i_clk      in   1                  clock, all state on rising edge
//  i_rst_n    in   1                  reset, asynchronous, active-low
//  i_w_e      in   W_CNT              write enables; only the leading run of 1s from bit 0 counts
//  i_w_data   in   WIDTH x W_CNT      write data, unpacked [0:W_CNT-1], port 0 oldest
//  o_w_ack    out  W_CNT              per-port write accepted this cycle (comb)
//  i_r_e      in   R_CNT              read enables; only the leading run of 1s from bit 0 counts
//  o_r_data   out  WIDTH x R_CNT      entries head+0 .. head+R_CNT-1 (comb from storage)
//  o_r_valid  out  R_CNT              o_r_data[i] holds a real entry
//  o_r_ack    out  R_CNT              per-port read consumed this cycle (comb)
//  i_flush    in   1                  synchronous discard of all contents
//  o_count    out  $clog2(DEPTH+1)    current occupancy
//  o_avail    out  1                  free >= W_CNT (a full-width write is guaranteed)
//  o_full     out  1                  count == DEPTH
//  o_empty    out  1                  count == 0
// BEHAVIOUR
//  - State: storage[DEPTH], w_ptr, r_ptr ($clog2(DEPTH) bits, wrap mod DEPTH), count register.
//  - Reset (async): w_ptr=r_ptr=0, count=0 -> o_count=0, o_empty=1, o_full=0, o_avail=1,
//    o_r_valid=0; o_w_ack=o_r_ack=0 while i_rst_n low. Storage contents not reset.
//  - Write: we_run = length of leading 1s in i_w_e; n_w = min(we_run, DEPTH - count).
//    o_w_ack[i] = (i < n_w). Port i writes storage[(w_ptr+i) mod DEPTH]. w_ptr += n_w.
//    A 0 at port k blocks ports > k even if their enables are 1.
//  - Free space uses registered count only: reads in same cycle do NOT free space for writes.
//  - Read: o_r_data[i] = storage[(r_ptr+i) mod DEPTH]; vld[i] = (i < count).
//    re_run = leading 1s of i_r_e; n_r = min(re_run, count); o_r_ack[i] = (i < n_r); r_ptr += n_r.
//    ALWAYS_READ=1: o_r_valid = vld. ALWAYS_READ=0: o_r_valid = o_r_ack.
//  - No write-to-read bypass: data written in cycle t readable from cycle t+1 (latency 1).
//  - count_next = count + n_w - n_r; simultaneous full-width read and write on same cycle legal.
//  - Wrap: pointer arithmetic modulo DEPTH; a multi-port access straddling index DEPTH-1 -> 0
//    must place entries contiguously in FIFO order.
//  - Flush: when i_flush=1, o_w_ack=o_r_ack=0 that cycle; next edge w_ptr=r_ptr=count=0.
//    Flush has priority over any write/read in the same cycle.
//  - Reset mid-traffic: immediate async clear; in-flight acks drop to 0 combinationally.
//  - Status outputs (o_count/o_avail/o_full/o_empty) derive from registered count only.
//  - Never overflow/underflow: count stays in [0, DEPTH] by construction; bench asserts it.
// TESTING (WIDTH=32, DEPTH=16, W_CNT=4, R_CNT=2, ALWAYS_READ=1)
//  1 Reset, then i_w_e=4'b1111 data A..D one cycle -> o_w_ack=1111; next cycle o_count=4,
//    o_r_data={A,B}, o_r_valid=11.
//  2 From count=4 (A..D), i_r_e=11 + i_w_e=1111 (E..H) same cycle -> r_ack=11, w_ack=1111,
//    next count=6, o_r_data={C,D}.
//  3 Fill to count=14, i_w_e=1111 -> o_w_ack=0011, o_avail=0 before; next o_count=16, o_full=1;
//    further i_w_e=0001 -> o_w_ack=0000.
//  4 Gap rule: empty FIFO, i_w_e=4'b1101 -> o_w_ack=0001, count=1; i_r_e=2'b10 -> o_r_ack=00.
//  5 Wrap: r_ptr=w_ptr=14, write 4 entries W0..W3 -> stored at idx 14,15,0,1; then two reads
//    return {W0,W1} then {W2,W3}, o_empty=1 after.
//  6 Flush with i_w_e=1111,i_r_e=11 at count=9 -> all acks 0; next o_count=0, o_empty=1,
//    o_r_valid=00; async reset mid-fill of 7 entries -> o_count=0 immediately.

Source files
------------

// File: rtl/fifo_mimo.sv
// Multi-write / multi-read circular FIFO: up to W_CNT in-order writes and R_CNT in-order
// reads per cycle, with exact occupancy, partial accept by free space and a synchronous flush.
module fifo_mimo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int W_CNT       = 4,
  parameter int R_CNT       = 2,
  parameter bit ALWAYS_READ = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [W_CNT-1:0]           i_w_e,
  input  logic [WIDTH-1:0]           i_w_data [0:W_CNT-1],
  output logic [W_CNT-1:0]           o_w_ack,
  input  logic [R_CNT-1:0]           i_r_e,
  output logic [WIDTH-1:0]           o_r_data [0:R_CNT-1],
  output logic [R_CNT-1:0]           o_r_valid,
  output logic [R_CNT-1:0]           o_r_ack,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_avail,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [0:DEPTH-1];
  logic [PW-1:0]    w_ptr, r_ptr;
  logic [CW-1:0]    count, free;
  logic [CW-1:0]    we_run, re_run, n_w, n_r;
  logic             w_blk, r_blk;
  logic [R_CNT-1:0] vld;

  function automatic logic [CW-1:0] min_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign free = CW'(DEPTH) - count;

  // Only the unbroken run of enables starting at port 0 is honoured.
  always_comb begin
    we_run = '0;
    w_blk  = 1'b0;
    for (int i = 0; i < W_CNT; i++) begin
      if (!i_w_e[i]) w_blk = 1'b1;
      if (!w_blk) we_run = CW'(i + 1);
    end
    n_w = min_cnt(we_run, free);
    if (i_flush || !i_rst_n) n_w = '0;
  end

  always_comb begin
    re_run = '0;
    r_blk  = 1'b0;
    for (int i = 0; i < R_CNT; i++) begin
      if (!i_r_e[i]) r_blk = 1'b1;
      if (!r_blk) re_run = CW'(i + 1);
    end
    n_r = min_cnt(re_run, count);
    if (i_flush || !i_rst_n) n_r = '0;
  end

  always_comb begin
    o_w_ack = '0;
    for (int i = 0; i < W_CNT; i++) o_w_ack[i] = (CW'(i) < n_w);
  end

  always_comb begin
    o_r_ack = '0;
    vld     = '0;
    for (int i = 0; i < R_CNT; i++) begin
      o_r_ack[i] = (CW'(i) < n_r);
      vld[i]     = (CW'(i) < count);
    end
  end

  generate
    if (ALWAYS_READ) begin : g_vld_occ
      assign o_r_valid = vld;
    end else begin : g_vld_ack
      assign o_r_valid = o_r_ack;
    end
  endgenerate

  // Head window is read straight from storage; pointer arithmetic wraps naturally.
  genvar g;
  generate
    for (g = 0; g < R_CNT; g++) begin : g_rd
      assign o_r_data[g] = storage[r_ptr + PW'(g)];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < W_CNT; i++) begin
      if (CW'(i) < n_w) storage[w_ptr + PW'(i)] <= i_w_data[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else if (i_flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      w_ptr <= w_ptr + PW'(n_w);
      r_ptr <= r_ptr + PW'(n_r);
      count <= count + n_w - n_r;
    end
  end

  assign o_count = count;
  assign o_avail = (free >= CW'(W_CNT));
  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);

endmodule

// File: tb/tb_fifo_mimo.sv
// Directed bench for fifo_mimo (WIDTH=32, DEPTH=16, W_CNT=4, R_CNT=2, ALWAYS_READ=1).
module tb_fifo_mimo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  w_e;
  logic [31:0] w_data [0:3];
  logic [3:0]  w_ack;
  logic [1:0]  r_e;
  logic [31:0] r_data [0:1];
  logic [1:0]  r_valid;
  logic [1:0]  r_ack;
  logic        flush;
  logic [4:0]  count;
  logic        avail, full, empty;

  int checks = 0;
  int errors = 0;

  fifo_mimo #(.WIDTH(32), .DEPTH(16), .W_CNT(4), .R_CNT(2), .ALWAYS_READ(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_w_e(w_e), .i_w_data(w_data), .o_w_ack(w_ack),
    .i_r_e(r_e), .o_r_data(r_data), .o_r_valid(r_valid), .o_r_ack(r_ack),
    .i_flush(flush), .o_count(count), .o_avail(avail), .o_full(full), .o_empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Occupancy must never leave [0, DEPTH].
  always @(negedge clk) check("count_bound", 32'(count <= 5'd16), 32'd1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] we, input logic [31:0] base, input logic [1:0] re);
    w_e = we;
    r_e = re;
    for (int i = 0; i < 4; i++) w_data[i] = base + 32'(i);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(4'b1111, 32'h0, 2'b11);
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_avail", 32'(avail), 32'd1);
    check("rst_rvalid", 32'(r_valid), 32'd0);
    check("rst_wack", 32'(w_ack), 32'd0);
    check("rst_rack", 32'(r_ack), 32'd0);
    drive(4'b0000, 32'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: full-width write A..D
    drive(4'b1111, 32'hA0, 2'b00);
    check("t1_wack", 32'(w_ack), 32'hF);
    tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t1_count", 32'(count), 32'd4);
    check("t1_rd0", r_data[0], 32'hA0);
    check("t1_rd1", r_data[1], 32'hA1);
    check("t1_rvalid", 32'(r_valid), 32'b11);

    // 2: simultaneous 2 reads and 4 writes (E..H)
    drive(4'b1111, 32'hA4, 2'b11);
    check("t2_rack", 32'(r_ack), 32'b11);
    check("t2_wack", 32'(w_ack), 32'hF);
    tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t2_count", 32'(count), 32'd6);
    check("t2_rd0", r_data[0], 32'hA2);
    check("t2_rd1", r_data[1], 32'hA3);

    // 3: fill to 14, then partial accept by free space
    drive(4'b1111, 32'h100, 2'b00); tick();
    drive(4'b1111, 32'h104, 2'b00); tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t3_count14", 32'(count), 32'd14);
    check("t3_avail", 32'(avail), 32'd0);
    drive(4'b1111, 32'h108, 2'b00);
    check("t3_wack_part", 32'(w_ack), 32'b0011);
    tick();
    drive(4'b0001, 32'h200, 2'b00);
    check("t3_count16", 32'(count), 32'd16);
    check("t3_full", 32'(full), 32'd1);
    check("t3_wack_full", 32'(w_ack), 32'b0000);
    // drain 16: order C D E F G H 100..109
    for (int k = 0; k < 8; k++) begin
      drive(4'b0000, 32'h0, 2'b11);
      if (k == 3) begin
        check("t3_drain3_0", r_data[0], 32'h100);
        check("t3_drain3_1", r_data[1], 32'h101);
      end
      if (k == 7) begin
        check("t3_drain7_0", r_data[0], 32'h108);
        check("t3_drain7_1", r_data[1], 32'h109);
      end
      tick();
    end
    drive(4'b0000, 32'h0, 2'b00);
    check("t3_empty", 32'(empty), 32'd1);

    // 4: enable gaps block later ports
    drive(4'b1101, 32'h300, 2'b00);
    check("t4_wack", 32'(w_ack), 32'b0001);
    tick();
    drive(4'b0000, 32'h0, 2'b10);
    check("t4_count", 32'(count), 32'd1);
    check("t4_rack", 32'(r_ack), 32'b00);
    tick();
    drive(4'b0000, 32'h0, 2'b01);
    check("t4_count_hold", 32'(count), 32'd1);
    check("t4_rd0", r_data[0], 32'h300);
    check("t4_rack1", 32'(r_ack), 32'b01);
    tick();
    // pointers now at 3; move both to 14 with 11 writes and 11 reads
    drive(4'b1111, 32'h400, 2'b00); tick();
    drive(4'b1111, 32'h404, 2'b00); tick();
    drive(4'b0111, 32'h408, 2'b00); tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0000, 32'h0, 2'b11); tick();
    end
    drive(4'b0000, 32'h0, 2'b01); tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t4_empty", 32'(empty), 32'd1);

    // 5: write straddling index 15 -> 0
    drive(4'b1111, 32'h500, 2'b00);
    check("t5_wack", 32'(w_ack), 32'hF);
    tick();
    drive(4'b0000, 32'h0, 2'b11);
    check("t5_rd0", r_data[0], 32'h500);
    check("t5_rd1", r_data[1], 32'h501);
    tick();
    drive(4'b0000, 32'h0, 2'b11);
    check("t5_rd2", r_data[0], 32'h502);
    check("t5_rd3", r_data[1], 32'h503);
    tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t5_empty", 32'(empty), 32'd1);

    // 6: flush at count 9, then async reset mid-fill
    drive(4'b1111, 32'h600, 2'b00); tick();
    drive(4'b1111, 32'h604, 2'b00); tick();
    drive(4'b0001, 32'h608, 2'b00); tick();
    drive(4'b0000, 32'h0, 2'b00);
    check("t6_count9", 32'(count), 32'd9);
    flush = 1'b1;
    drive(4'b1111, 32'h700, 2'b11);
    check("t6_flush_wack", 32'(w_ack), 32'd0);
    check("t6_flush_rack", 32'(r_ack), 32'd0);
    tick();
    flush = 1'b0;
    drive(4'b0000, 32'h0, 2'b00);
    check("t6_flush_count", 32'(count), 32'd0);
    check("t6_flush_empty", 32'(empty), 32'd1);
    check("t6_flush_rvalid", 32'(r_valid), 32'b00);
    drive(4'b1111, 32'h800, 2'b00); tick();
    drive(4'b0111, 32'h804, 2'b00); tick();
    drive(4'b1111, 32'h900, 2'b00);
    check("t6_count7", 32'(count), 32'd7);
    check("t6_wack_pre", 32'(w_ack), 32'hF);
    rst_n = 1'b0;
    #1;
    check("t6_arst_count", 32'(count), 32'd0);
    check("t6_arst_wack", 32'(w_ack), 32'd0);
    check("t6_arst_empty", 32'(empty), 32'd1);
    drive(4'b0000, 32'h0, 2'b00);
    rst_n = 1'b1;
    tick();
    check("t6_post_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
